countdown_timer: RTL and testbench

- Four-digit MM:SS BCD countdown timer for the irrigation controller; sets how long a zone waters.
- Complements the existing up-counting stopwatch: loads a preset, decrements once per second, pauses and resumes, and flags expiry.
- Drives the same multiplexed 4-digit common-anode 7-segment display scheme, so either block can own the display.

---
 rtl/irrig_pkg.sv | 45 ++++
 rtl/bcd_down_digit.sv | 30 +++
 rtl/countdown_timer.sv | 169 ++++++++++++++++
 tb/tb_countdown_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation controller's timing blocks.
package irrig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    localparam int BCD_MAX_UNITS    = 9;
    localparam int BCD_MAX_SEC_TENS = 5;

    // Segment patterns ordered {a,b,c,d,e,f,g}, 1 = lit
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counting borrow chain; wraps 0 -> MAX and borrows.
module bcd_down_digit #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    output logic [3:0] q,
    output logic       borrow_out
);

    logic [3:0] q_q;

    // Load has priority over decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else if (load) begin
            q_q <= load_val;
        end else if (dec_en) begin
            q_q <= (q_q == 4'd0) ? 4'(MAX) : q_q - 4'd1;
        end
    end

    assign q          = q_q;
    assign borrow_out = dec_en && (q_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with pause/resume, expiry flag and 4-digit
// multiplexed 7-segment drive.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | preset loaded (or reset), waiting for start
// ST_RUN   | decrementing one second per tick_1hz
// ST_PAUSE | count held, start resumes
// ST_DONE  | reached 00:00, expired held until load/reset
module countdown_timer
    import irrig_pkg::*;
#(
    parameter bit DIG_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter int MAX_DZ_MIN  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       scan_tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_dz_min,
    input  logic [3:0] preset_und_min,
    input  logic [3:0] preset_dz_sec,
    input  logic [3:0] preset_und_sec,
    output logic [3:0] dz_min,
    output logic [3:0] und_min,
    output logic [3:0] dz_sec,
    output logic [3:0] und_sec,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       load_err,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g
);

    timer_state_t state_q, state_d;
    logic         done_q, done_d;
    logic         load_err_q;
    logic [1:0]   idx_q, idx_d;
    logic [3:0]   en_q;
    logic [6:0]   seg_q;
    logic [3:0]   shown_digit;

    logic preset_ok, load_ok, count_zero, last_sec, tick_dec;
    logic brw_us, brw_ds, brw_um, brw_dm;

    assign preset_ok = (preset_und_sec <= 4'(BCD_MAX_UNITS))
                    && (preset_dz_sec  <= 4'(BCD_MAX_SEC_TENS))
                    && (preset_und_min <= 4'(BCD_MAX_UNITS))
                    && (preset_dz_min  <= 4'(MAX_DZ_MIN));
    assign load_ok    = load && preset_ok;
    assign count_zero = ({dz_min, und_min, dz_sec, und_sec} == 16'h0000);
    assign last_sec   = ({dz_min, und_min, dz_sec, und_sec} == 16'h0001);
    // Any higher-priority command in the same cycle swallows the tick
    assign tick_dec   = tick_1hz && (state_q == ST_RUN) && !load && !start && !pause;

    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_und_sec (
        .clk(clk), .rst_n(rst_n), .load(load_ok), .load_val(preset_und_sec),
        .dec_en(tick_dec), .q(und_sec), .borrow_out(brw_us)
    );
    bcd_down_digit #(.MAX(BCD_MAX_SEC_TENS)) u_dz_sec (
        .clk(clk), .rst_n(rst_n), .load(load_ok), .load_val(preset_dz_sec),
        .dec_en(brw_us), .q(dz_sec), .borrow_out(brw_ds)
    );
    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_und_min (
        .clk(clk), .rst_n(rst_n), .load(load_ok), .load_val(preset_und_min),
        .dec_en(brw_ds), .q(und_min), .borrow_out(brw_um)
    );
    // In RUN the count is never 00:00, so this digit never actually wraps
    bcd_down_digit #(.MAX(MAX_DZ_MIN)) u_dz_min (
        .clk(clk), .rst_n(rst_n), .load(load_ok), .load_val(preset_dz_min),
        .dec_en(brw_um), .q(dz_min), .borrow_out(brw_dm)
    );

    // Next state with priority load > start > pause > tick
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            if (preset_ok) state_d = ST_IDLE;
        end else if (start) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                if (count_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else if (pause) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else if (tick_dec && last_sec) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
        end
    end

    // State and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            load_err_q <= load && !preset_ok;
        end
    end

    assign idx_d = scan_tick ? idx_q + 2'd1 : idx_q;

    // Digit shown at the upcoming index; d0 is minutes tens
    always_comb begin
        shown_digit = dz_min;
        case (idx_d)
            2'd0: shown_digit = dz_min;
            2'd1: shown_digit = und_min;
            2'd2: shown_digit = dz_sec;
            2'd3: shown_digit = und_sec;
            default: shown_digit = dz_min;
        endcase
    end

    // Display registers: enable and segments refresh every cycle from the next index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            en_q  <= 4'b0001;
            seg_q <= SEG_0;
        end else begin
            idx_q <= idx_d;
            en_q  <= 4'b0001 << idx_d;
            seg_q <= seg_lookup(shown_digit);
        end
    end

    assign running  = (state_q == ST_RUN);
    assign expired  = (state_q == ST_DONE);
    assign done     = done_q;
    assign load_err = load_err_q;

    assign d0 = en_q[0] ^ DIG_ACT_LOW;
    assign d1 = en_q[1] ^ DIG_ACT_LOW;
    assign d2 = en_q[2] ^ DIG_ACT_LOW;
    assign d3 = en_q[3] ^ DIG_ACT_LOW;

    assign a = seg_q[6] ^ SEG_ACT_LOW;
    assign b = seg_q[5] ^ SEG_ACT_LOW;
    assign c = seg_q[4] ^ SEG_ACT_LOW;
    assign d = seg_q[3] ^ SEG_ACT_LOW;
    assign e = seg_q[2] ^ SEG_ACT_LOW;
    assign f = seg_q[1] ^ SEG_ACT_LOW;
    assign g = seg_q[0] ^ SEG_ACT_LOW;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with default parameters (active-low display).
module tb_countdown_timer;

    logic       clk, rst_n, tick_1hz, scan_tick, load, start, pause;
    logic [3:0] p_dm, p_um, p_ds, p_us;
    logic [3:0] dz_min, und_min, dz_sec, und_sec;
    logic       running, expired, done, load_err;
    logic       d0, d1, d2, d3;
    logic       sa, sb, sc, sd, se, sf, sg;

    int errors = 0;
    int checks = 0;

    countdown_timer dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .scan_tick(scan_tick),
        .load(load), .start(start), .pause(pause),
        .preset_dz_min(p_dm), .preset_und_min(p_um),
        .preset_dz_sec(p_ds), .preset_und_sec(p_us),
        .dz_min(dz_min), .und_min(und_min), .dz_sec(dz_sec), .und_sec(und_sec),
        .running(running), .expired(expired), .done(done), .load_err(load_err),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt();
        return {dz_min, und_min, dz_sec, und_sec};
    endfunction

    // Active-low segment levels {a..g} for a decimal digit
    function automatic logic [6:0] seg_exp(input int dig);
        logic [6:0] lit;
        case (dig)
            0: lit = 7'b1111110;
            1: lit = 7'b0110000;
            2: lit = 7'b1101101;
            3: lit = 7'b1111001;
            4: lit = 7'b0110011;
            default: lit = 7'b0000000;
        endcase
        return ~lit;
    endfunction

    task automatic do_load(input logic [15:0] val);
        {p_dm, p_um, p_ds, p_us} = val;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    initial begin
        logic [3:0] en_tbl [4];
        int         dig_tbl [4];
        en_tbl  = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
        dig_tbl = '{2, 3, 4, 1};

        rst_n = 1'b0; tick_1hz = 1'b0; scan_tick = 1'b0;
        load = 1'b0; start = 1'b0; pause = 1'b0;
        {p_dm, p_um, p_ds, p_us} = 16'h0000;
        #12;
        chk("rst_count",   cnt(), 16'h0000);
        chk("rst_flags",   {12'd0, running, expired, done, load_err}, 16'h0000);
        chk("rst_digits",  {12'd0, d0, d1, d2, d3}, 16'h0007);
        chk("rst_segs",    {9'd0, sa, sb, sc, sd, se, sf, sg}, {9'd0, seg_exp(0)});
        rst_n = 1'b1;
        step();

        // 00:03 runs out on the third tick
        do_load(16'h0003);
        chk("l3_count", cnt(), 16'h0003);
        pulse_start();
        chk("l3_running", {15'd0, running}, 16'd1);
        pulse_tick();
        chk("l3_t1", cnt(), 16'h0002);
        pulse_tick();
        chk("l3_t2", cnt(), 16'h0001);
        chk("l3_t2_done", {15'd0, done}, 16'd0);
        pulse_tick();
        chk("l3_t3", cnt(), 16'h0000);
        chk("l3_t3_flags", {13'd0, running, expired, done}, 16'b011);
        step();
        chk("l3_done_1cyc", {14'd0, expired, done}, 16'b10);
        pulse_tick();
        chk("l3_no_underflow", cnt(), 16'h0000);

        // full borrow chain
        do_load(16'h1000);
        chk("l10_expired_clr", {15'd0, expired}, 16'd0);
        pulse_start();
        pulse_tick();
        chk("l10_borrow", cnt(), 16'h0959);

        // pause / resume, tick coinciding with start is dropped
        do_load(16'h0130);
        pulse_start();
        for (int i = 0; i < 5; i++) pulse_tick();
        chk("p_5ticks", cnt(), 16'h0125);
        pause = 1'b1; step(); pause = 1'b0;
        chk("p_paused", {15'd0, running}, 16'd0);
        for (int i = 0; i < 4; i++) pulse_tick();
        chk("p_hold", cnt(), 16'h0125);
        start = 1'b1; tick_1hz = 1'b1; step(); start = 1'b0; tick_1hz = 1'b0;
        chk("p_start_tick", cnt(), 16'h0125);
        chk("p_resumed", {15'd0, running}, 16'd1);
        pulse_tick();
        chk("p_resume_tick", cnt(), 16'h0124);

        // rejected preset (dz_sec = 7)
        do_load(16'h0670);
        chk("bad_err", {15'd0, load_err}, 16'd1);
        chk("bad_count", cnt(), 16'h0124);
        chk("bad_state", {15'd0, running}, 16'd1);
        step();
        chk("bad_err_1cyc", {15'd0, load_err}, 16'd0);

        // start on zero count goes straight to DONE
        do_load(16'h0000);
        chk("z_idle", {14'd0, running, expired}, 16'd0);
        pulse_start();
        chk("z_done", {13'd0, running, expired, done}, 16'b011);
        step();
        chk("z_done_1cyc", {15'd0, done}, 16'd0);

        // load beats start in RUN
        do_load(16'h0500);
        pulse_start();
        {p_dm, p_um, p_ds, p_us} = 16'h0222;
        load = 1'b1; start = 1'b1; step(); load = 1'b0; start = 1'b0;
        chk("ls_count", cnt(), 16'h0222);
        chk("ls_idle", {14'd0, running, expired}, 16'd0);
        pulse_start();
        pulse_tick();
        chk("ls_tick", cnt(), 16'h0221);

        // asynchronous reset mid-RUN
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", cnt(), 16'h0000);
        chk("ar_flags", {12'd0, running, expired, done, load_err}, 16'd0);
        chk("ar_digits", {12'd0, d0, d1, d2, d3}, 16'h0007);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_no_done", {15'd0, done}, 16'd0);

        // display scan over 12:34
        do_load(16'h1234);
        step();
        chk("sc_idx0_seg", {9'd0, sa, sb, sc, sd, se, sf, sg}, {9'd0, seg_exp(1)});
        for (int i = 0; i < 4; i++) begin
            scan_tick = 1'b1;
            @(posedge clk);
            #1;
            scan_tick = 1'b0;
            chk($sformatf("sc_en%0d", i), {12'd0, d0, d1, d2, d3}, {12'd0, en_tbl[i]});
            chk($sformatf("sc_seg%0d", i), {9'd0, sa, sb, sc, sd, se, sf, sg},
                {9'd0, seg_exp(dig_tbl[i])});
            step();
            chk($sformatf("sc_hold%0d", i), {12'd0, d0, d1, d2, d3}, {12'd0, en_tbl[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
